rtype_issue_ctrl: RTL

- Multi-cycle issue controller that drives the initiator side of the register-file/ALU datapath.
- Accepts 32-bit MIPS R-type instruction words over a valid/ready handshake and decodes them.
- Drives the register file read addresses, the ALU op/shift count, the write-back mux select, and the write enable.
- Retires one instruction per 4 cycles; reports completion, zero flag, illegal-instruction status and a retired-instruction count.

---
 rtl/rtype_issue_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rtype_issue_ctrl.sv
// Four-cycle issue controller for MIPS R-type instructions: latches a word,
// decodes it onto the register-file/ALU control lines and retires it with a write pulse.
module rtype_issue_ctrl #(
  parameter int CNT_W = 16,
  parameter int RF_AW = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      Instr,
  input  logic             Instr_Valid,
  output logic             Instr_Ready,
  input  logic             Zero,
  output logic [RF_AW-1:0] RR1,
  output logic [RF_AW-1:0] RR2,
  output logic [RF_AW-1:0] WR,
  output logic             WE,
  output logic [3:0]       ALU_Op,
  output logic [4:0]       ShiftCount,
  output logic             Mux_Ctrl,
  output logic             Done,
  output logic             Zero_Flag,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [RF_AW-1:0]   rr1_q, rr1_d, rr2_q, rr2_d, wr_q, wr_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [4:0]         shamt_q, shamt_d;
  logic               mux_q, mux_d;
  logic               zero_flag_q, zero_flag_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               dec_legal, dec_shift;
  logic [3:0]         dec_op;
  logic [RF_AW-1:0]   dec_rr1, dec_rr2, dec_wr;
  logic [4:0]         dec_shamt;
  logic               show_dec;

  // Decode always works on the latched copy, never on the live Instr bus.
  always_comb begin
    dec_legal = (instr_q[31:26] == 6'd0);
    dec_shift = 1'b0;
    dec_op    = 4'b0000;
    case (instr_q[5:0])
      6'h20:   dec_op = 4'b0010;
      6'h22:   dec_op = 4'b0110;
      6'h24:   dec_op = 4'b0000;
      6'h25:   dec_op = 4'b0001;
      6'h27:   dec_op = 4'b1100;
      6'h2A:   dec_op = 4'b0111;
      6'h00:   begin dec_op = 4'b1110; dec_shift = 1'b1; end
      6'h02:   begin dec_op = 4'b1101; dec_shift = 1'b1; end
      6'h03:   begin dec_op = 4'b1111; dec_shift = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
    dec_rr1   = dec_shift ? RF_AW'(instr_q[20:16]) : RF_AW'(instr_q[25:21]);
    dec_rr2   = RF_AW'(instr_q[20:16]);
    dec_wr    = RF_AW'(instr_q[15:11]);
    dec_shamt = dec_shift ? instr_q[10:6] : 5'd0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      rr1_q       <= '0;
      rr2_q       <= '0;
      wr_q        <= '0;
      alu_op_q    <= '0;
      shamt_q     <= '0;
      mux_q       <= 1'b0;
      zero_flag_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rr1_q       <= rr1_d;
      rr2_q       <= rr2_d;
      wr_q        <= wr_d;
      alu_op_q    <= alu_op_d;
      shamt_q     <= shamt_d;
      mux_q       <= mux_d;
      zero_flag_q <= zero_flag_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (Instr_Valid) state_d = DECODE;
      DECODE:    state_d = dec_legal ? EXECUTE : IDLE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath control registers capture the decode on leaving DECODE and hold afterwards.
  always_comb begin
    instr_d     = instr_q;
    rr1_d       = rr1_q;
    rr2_d       = rr2_q;
    wr_d        = wr_q;
    alu_op_d    = alu_op_q;
    shamt_d     = shamt_q;
    mux_d       = mux_q;
    zero_flag_d = zero_flag_q;
    retired_d   = retired_q;
    if (state_q == IDLE && Instr_Valid) instr_d = Instr;
    if (state_q == DECODE && dec_legal) begin
      rr1_d    = dec_rr1;
      rr2_d    = dec_rr2;
      wr_d     = dec_wr;
      alu_op_d = dec_op;
      shamt_d  = dec_shamt;
      mux_d    = 1'b1;
    end
    if (state_q == WRITEBACK) begin
      zero_flag_d = Zero;
      retired_d   = retired_q + CNT_W'(1);
    end
  end

  // During DECODE the fresh decode is driven straight out so the datapath sees it a cycle early.
  always_comb begin
    show_dec    = (state_q == DECODE) && dec_legal;
    Instr_Ready = (state_q == IDLE);
    RR1         = show_dec ? dec_rr1   : rr1_q;
    RR2         = show_dec ? dec_rr2   : rr2_q;
    WR          = show_dec ? dec_wr    : wr_q;
    ALU_Op      = show_dec ? dec_op    : alu_op_q;
    ShiftCount  = show_dec ? dec_shamt : shamt_q;
    Mux_Ctrl    = show_dec ? 1'b1      : mux_q;
    WE          = (state_q == WRITEBACK) && (wr_q != '0);
    Done        = (state_q == WRITEBACK);
    Illegal     = (state_q == DECODE) && !dec_legal;
    Zero_Flag   = zero_flag_q;
    Retired     = retired_q;
  end

endmodule
